// File: rtl/fifo_push_arbiter.sv
// Purpose: round-robin arbiter sharing one FIFO push port among NUM_REQ producers, bounded bursts of MAX_BURST.
// Latency: zero-cycle req->gnt in IDLE; one idle bubble after every ownership period that ends from BURST.
// Backpressure: no grant while fifo_full_i; a stalled owner keeps ownership. Optional FIFO_ARB_STALL_CNT_EN adds stall_cnt_o.
module fifo_push_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 4,
    localparam int OW       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req_i,
    input  logic [NUM_REQ*DATA_W-1:0]  req_data_i,
    input  logic [NUM_REQ-1:0]         req_last_i,
    output logic [NUM_REQ-1:0]         gnt_o,
    output logic                       fifo_push_o,
    output logic [DATA_W-1:0]          fifo_push_data_o,
    input  logic                       fifo_full_i,
    output logic                       busy_o,
    output logic [OW-1:0]              owner_o
`ifdef FIFO_ARB_STALL_CNT_EN
    ,
    output logic [15:0]                stall_cnt_o
`endif
);

    typedef enum logic {IDLE, BURST} state_t;

    state_t             state;
    logic [3:0]         count;
    logic [OW-1:0]      last_owner;
    logic               bubble;      // first IDLE cycle after a burst ended on a push: no grant
    logic               win_vld;
    logic [OW-1:0]      win_idx;
    logic [NUM_REQ-1:0] gnt;

    // Round-robin search starting just after the last owner, wrapping modulo NUM_REQ
    always_comb begin
        int            idx;
        logic [OW-1:0] cand;
        win_vld = 1'b0;
        win_idx = '0;
        idx     = 0;
        cand    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx  = (int'(last_owner) + k) % NUM_REQ;
            cand = OW'(idx);
            if (!win_vld && req_i[cand]) begin
                win_vld = 1'b1;
                win_idx = cand;
            end
        end
    end

    // Grant: arbitration winner in IDLE, only the owner in BURST; never into a full FIFO or during reset
    always_comb begin
        gnt = '0;
        if (!reset && !fifo_full_i) begin
            if (state == IDLE) begin
                if (win_vld && !bubble) begin
                    gnt[win_idx] = 1'b1;
                end
            end else if (req_i[owner_o]) begin
                gnt[owner_o] = 1'b1;
            end
        end
    end

    // Push data mux: granted requester's slice, zero when nobody is granted
    always_comb begin
        fifo_push_data_o = '0;
        for (int r = 0; r < NUM_REQ; r++) begin
            if (gnt[r]) begin
                fifo_push_data_o = req_data_i[r*DATA_W +: DATA_W];
            end
        end
    end

    assign gnt_o       = gnt;
    assign fifo_push_o = |gnt;

    // Ownership FSM: burst counting, exit on last/cap/owner drop, pointer update on exit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            busy_o     <= 1'b0;
            owner_o    <= '0;
            count      <= 4'd0;
            last_owner <= OW'(NUM_REQ - 1);
            bubble     <= 1'b0;
        end else begin
            bubble <= 1'b0;
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        owner_o <= win_idx;
                        count   <= 4'd1;
                        if (req_last_i[win_idx] || MAX_BURST == 1) begin
                            last_owner <= win_idx;
                        end else begin
                            state  <= BURST;
                            busy_o <= 1'b1;
                        end
                    end
                end
                BURST: begin
                    if (|gnt) begin
                        count <= count + 4'd1;
                        if (req_last_i[owner_o] || (count + 4'd1 == 4'(MAX_BURST))) begin
                            state      <= IDLE;
                            busy_o     <= 1'b0;
                            last_owner <= owner_o;
                            bubble     <= 1'b1;
                        end
                    end else if (!req_i[owner_o]) begin
                        // owner gave up: this no-push cycle is already the bubble
                        state      <= IDLE;
                        busy_o     <= 1'b0;
                        last_owner <= owner_o;
                    end
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

`ifdef FIFO_ARB_STALL_CNT_EN
    // Saturating count of cycles where someone wants to push but the FIFO is full
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_o <= 16'd0;
        end else if ((|req_i) && fifo_full_i && (stall_cnt_o != 16'hFFFF)) begin
            stall_cnt_o <= stall_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// Purpose: directed bench for fifo_push_arbiter with a depth-8 FIFO model and per-requester word queues.
// Latency: inputs change 1 time unit after posedge, outputs sampled on negedge.
// Backpressure: fifo_full_i comes from the bench FIFO model occupancy.
module tb_fifo_push_arbiter;

    localparam int NR = 4;
    localparam int DW = 16;
    localparam int DEPTH = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic [NR-1:0]   req_i = '0;
    logic [NR*DW-1:0] req_data_i = '0;
    logic [NR-1:0]   req_last_i = '0;
    logic [NR-1:0]   gnt_o;
    logic            fifo_push_o;
    logic [DW-1:0]   fifo_push_data_o;
    logic            fifo_full_i = 1'b0;
    logic            busy_o;
    logic [1:0]      owner_o;
`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0]     stall_cnt_o;
`endif

    fifo_push_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_i            (req_i),
        .req_data_i       (req_data_i),
        .req_last_i       (req_last_i),
        .gnt_o            (gnt_o),
        .fifo_push_o      (fifo_push_o),
        .fifo_push_data_o (fifo_push_data_o),
        .fifo_full_i      (fifo_full_i),
        .busy_o           (busy_o),
        .owner_o          (owner_o)
`ifdef FIFO_ARB_STALL_CNT_EN
        ,
        .stall_cnt_o      (stall_cnt_o)
`endif
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    // per-requester pending words {last, data}; FIFO model contents
    logic [16:0] rq [NR][$];
    logic [15:0] fq [$];

    // values captured at the negedge of the last step
    logic [NR-1:0] cg;
    logic          cp;
    logic [DW-1:0] cd;
    logic          cb;
    logic [1:0]    co;
    logic [15:0]   popped;

    task automatic drive();
        for (int r = 0; r < NR; r++) begin
            if (rq[r].size() > 0) begin
                req_i[r]                 = 1'b1;
                req_data_i[r*DW +: DW]   = rq[r][0][15:0];
                req_last_i[r]            = rq[r][0][16];
            end else begin
                req_i[r]                 = 1'b0;
                req_data_i[r*DW +: DW]   = '0;
                req_last_i[r]            = 1'b0;
            end
        end
        fifo_full_i = (fq.size() >= DEPTH);
    endtask

    // one clock: sample at negedge, apply handshake/FIFO effects at posedge, redrive at +1
    task automatic step(input logic pop);
        @(negedge clk);
        cg = gnt_o; cp = fifo_push_o; cd = fifo_push_data_o; cb = busy_o; co = owner_o;
        @(posedge clk);
        for (int r = 0; r < NR; r++) begin
            if (cg[r] && rq[r].size() > 0) void'(rq[r].pop_front());
        end
        if (pop) begin
            if (fq.size() > 0) popped = fq.pop_front();
            else popped = 'x;
        end
        if (cp) fq.push_back(cd);
        #1 drive();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        for (int r = 0; r < NR; r++) rq[r].delete();
        fq.delete();
        drive();
        repeat (2) @(posedge clk);
        #3 reset = 1'b0;
    endtask

    task automatic test_reset();
        for (int r = 0; r < NR; r++) rq[r].push_back({1'b1, 16'h5000 + 16'(r)});
        drive();
        #12;
        n_chk++;
        if (gnt_o !== 4'b0000 || fifo_push_o !== 1'b0 || fifo_push_data_o !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_grant: gnt=%b push=%b data=%h, expected 0000/0/0000", gnt_o, fifo_push_o, fifo_push_data_o);
        end
        n_chk++;
        if (busy_o !== 1'b0 || owner_o !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b owner=%0d, expected 0/0", busy_o, owner_o);
        end
`ifdef FIFO_ARB_STALL_CNT_EN
        n_chk++;
        if (stall_cnt_o !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_stall: stall_cnt=%0d, expected 0", stall_cnt_o);
        end
`endif
        @(posedge clk);
        #3 reset = 1'b0;
        step(1'b0);
        n_chk++;
        if (cg !== 4'b0001 || cd !== 16'h5000) begin
            n_fail++;
            $display("FAIL reset_first_winner: gnt=%b data=%h, expected 0001/5000", cg, cd);
        end
    endtask

    task automatic test_single();
        logic [3:0] eg [4];
        logic       eb [4];
        eg = '{4'b0001, 4'b0001, 4'b0001, 4'b0000};
        eb = '{1'b0, 1'b1, 1'b1, 1'b0};
        do_reset();
        rq[0].push_back({1'b0, 16'h1111});
        rq[0].push_back({1'b0, 16'h1111});
        rq[0].push_back({1'b1, 16'h1111});
        drive();
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            n_chk++;
            if (cg !== eg[i] || cb !== eb[i] || cp !== (eg[i] != 4'b0000)) begin
                n_fail++;
                $display("FAIL single step %0d: gnt=%b busy=%b push=%b, expected gnt=%b busy=%b", i, cg, cb, cp, eg[i], eb[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1);
            n_chk++;
            if (popped !== 16'h1111) begin
                n_fail++;
                $display("FAIL single_pop %0d: got %h, expected 1111", i, popped);
            end
        end
        n_chk++;
        if (fq.size() != 0) begin
            n_fail++;
            $display("FAIL single_count: fifo holds %0d words, expected 0", fq.size());
        end
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int k = 0; k < 2; k++)
            for (int r = 0; r < NR; r++)
                rq[r].push_back({1'b1, 16'hA000 + 16'(r*256 + k)});
        drive();
        for (int i = 0; i < 8; i++) begin
            logic [3:0]  eg;
            logic [15:0] ed;
            eg = 4'b0001 << (i % 4);
            ed = 16'hA000 + 16'((i % 4)*256 + i/4);
            step(1'b0);
            n_chk++;
            if (cg !== eg || cp !== 1'b1 || cd !== ed || cb !== 1'b0) begin
                n_fail++;
                $display("FAIL rr step %0d: gnt=%b push=%b data=%h busy=%b, expected gnt=%b push=1 data=%h busy=0", i, cg, cp, cd, cb, eg, ed);
            end
            if (i > 0) begin
                n_chk++;
                if (co !== 2'((i-1) % 4)) begin
                    n_fail++;
                    $display("FAIL rr_owner step %0d: owner=%0d, expected %0d", i, co, (i-1) % 4);
                end
            end
        end
    endtask

    task automatic test_burst_cap();
        logic [3:0] eg [7];
        logic       eb [7];
        eg = '{4'b0100, 4'b0100, 4'b0100, 4'b0100, 4'b0000, 4'b0001, 4'b0100};
        eb = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int k = 0; k < 6; k++) rq[2].push_back({1'b0, 16'h2200 + 16'(k)});
        drive();
        for (int i = 0; i < 7; i++) begin
            step(1'b0);
            if (i == 0) begin
                rq[0].push_back({1'b1, 16'h0A0A});
                drive();
            end
            n_chk++;
            if (cg !== eg[i] || cb !== eb[i]) begin
                n_fail++;
                $display("FAIL burst_cap step %0d: gnt=%b busy=%b, expected gnt=%b busy=%b", i, cg, cb, eg[i], eb[i]);
            end
            if (i == 5) begin
                n_chk++;
                if (cd !== 16'h0A0A || co !== 2'd2) begin
                    n_fail++;
                    $display("FAIL burst_cap_switch: data=%h owner=%0d, expected 0a0a/2", cd, co);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [3:0] eg [16];
        logic       eb [16];
        eg = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0010,
               4'b0010, 4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0010};
        eb = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
               1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        do_reset();
        for (int k = 0; k < 10; k++)
            rq[1].push_back({(k == 2 || k == 4 || k == 9), 16'h1100 + 16'(k)});
        drive();
        for (int i = 0; i < 16; i++) begin
            step(i == 11 || i == 14);
            n_chk++;
            if (cg !== eg[i] || cb !== eb[i]) begin
                n_fail++;
                $display("FAIL backpressure step %0d: gnt=%b busy=%b, expected gnt=%b busy=%b", i, cg, cb, eg[i], eb[i]);
            end
            if (i == 10 || i == 12) begin
                n_chk++;
                if (co !== 2'd1) begin
                    n_fail++;
                    $display("FAIL bp_owner step %0d: owner=%0d, expected 1", i, co);
                end
            end
            if (i == 11 || i == 14) begin
                n_chk++;
                if (popped !== 16'h1100 + 16'(i == 14)) begin
                    n_fail++;
                    $display("FAIL bp_pop step %0d: got %h, expected %h", i, popped, 16'h1100 + 16'(i == 14));
                end
            end
        end
`ifdef FIFO_ARB_STALL_CNT_EN
        n_chk++;
        if (stall_cnt_o !== 16'd4) begin
            n_fail++;
            $display("FAIL bp_stall_cnt: stall_cnt=%0d, expected 4", stall_cnt_o);
        end
`endif
        for (int i = 0; i < 8; i++) begin
            step(1'b1);
            n_chk++;
            if (popped !== 16'h1102 + 16'(i)) begin
                n_fail++;
                $display("FAIL bp_drain %0d: got %h, expected %h", i, popped, 16'h1102 + 16'(i));
            end
        end
        n_chk++;
        if (fq.size() != 0 || rq[1].size() != 0) begin
            n_fail++;
            $display("FAIL bp_leftover: fifo=%0d pending=%0d, expected 0/0", fq.size(), rq[1].size());
        end
    endtask

    task automatic test_owner_drop();
        logic [3:0] eg [5];
        logic       eb [5];
        eg = '{4'b1000, 4'b1000, 4'b0000, 4'b0001, 4'b0010};
        eb = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        rq[3].push_back({1'b0, 16'h3300});
        rq[3].push_back({1'b0, 16'h3301});
        drive();
        for (int i = 0; i < 5; i++) begin
            step(1'b0);
            if (i == 0) begin
                rq[0].push_back({1'b1, 16'h0B0B});
                rq[1].push_back({1'b1, 16'h0C0C});
                drive();
            end
            n_chk++;
            if (cg !== eg[i] || cb !== eb[i]) begin
                n_fail++;
                $display("FAIL owner_drop step %0d: gnt=%b busy=%b, expected gnt=%b busy=%b", i, cg, cb, eg[i], eb[i]);
            end
        end
        n_chk++;
        if (fq.size() != 4 || fq[2] !== 16'h0B0B || fq[3] !== 16'h0C0C) begin
            n_fail++;
            $display("FAIL owner_drop_order: fifo size %0d, expected 4 words ending 0b0b,0c0c", fq.size());
        end
    endtask

    task automatic test_reset_mid_burst();
        do_reset();
        for (int k = 0; k < 4; k++) rq[2].push_back({1'b0, 16'h2D00 + 16'(k)});
        drive();
        step(1'b0);
        step(1'b0);
        n_chk++;
        if (cg !== 4'b0100 || busy_o !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_setup: gnt=%b busy=%b, expected 0100/1", cg, busy_o);
        end
        rq[0].push_back({1'b1, 16'h0D0D});
        drive();
        #2 reset = 1'b1;
        #1;
        n_chk++;
        if (busy_o !== 1'b0 || gnt_o !== 4'b0000 || fifo_push_o !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: busy=%b gnt=%b push=%b, expected 0/0000/0", busy_o, gnt_o, fifo_push_o);
        end
`ifdef FIFO_ARB_STALL_CNT_EN
        n_chk++;
        if (stall_cnt_o !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_stall_cnt: stall_cnt=%0d, expected 0", stall_cnt_o);
        end
`endif
        reset = 1'b0;
        step(1'b0);
        n_chk++;
        if (cg !== 4'b0001 || cd !== 16'h0D0D) begin
            n_fail++;
            $display("FAIL mid_first_winner: gnt=%b data=%h, expected 0001/0d0d", cg, cd);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_burst_cap();
        test_backpressure();
        test_owner_drop();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
